cordic_atan2: RTL and testbench

CORDIC_ATAN2 -- requirements
Module: cordic_atan2

---
 rtl/cordic_atan2_pkg.sv | 36 +++
 rtl/cordic_atan2_stage.sv | 43 ++++
 rtl/cordic_atan2.sv | 138 +++++++++++++
 tb/tb_cordic_atan2.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_atan2_pkg.sv
// Shared definitions for the CORDIC atan2 block.
//   state_t   : controller states (IDLE, ROT, DONE)
//   PHASE_W   : output phase width, a 15-bit fraction of a full turn
//   QUARTER   : 90 degrees in phase units
//   HALF      : 180 degrees in phase units
//   ATAN_TAB  : micro-rotation angles round(atan(2^-k)/(2*pi) * 2^18), k = 0..15
//   phase_to_z: widens a phase value into the guarded angle accumulator format
package cordic_atan2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PHASE_W = 15;
    localparam int Z_GUARD = 3;
    localparam int Z_W     = PHASE_W + Z_GUARD;
    localparam int XY_FRAC = 4;

    localparam logic [PHASE_W-1:0] QUARTER = 15'h2000;
    localparam logic [PHASE_W-1:0] HALF    = 15'h4000;

    // Index 0 is the rightmost entry.
    localparam logic [15:0][Z_W-1:0] ATAN_TAB = {
        18'd1,    18'd3,    18'd5,     18'd10,
        18'd20,   18'd41,   18'd81,    18'd163,
        18'd326,  18'd652,  18'd1303,  18'd2604,
        18'd5188, 18'd10221, 18'd19344, 18'd32768
    };

    function automatic logic [Z_W-1:0] phase_to_z(input logic [PHASE_W-1:0] p);
        return {p, {Z_GUARD{1'b0}}};
    endfunction

endpackage

// File: rtl/cordic_atan2_stage.sv
// One combinational CORDIC vectoring micro-rotation.
//   x_in, y_in, z_in : current vector and accumulated angle
//   shift            : iteration index k (arithmetic shift amount)
//   angle            : atan(2^-k) in accumulator units
//   x_out, y_out     : rotated vector (rotation drives y toward zero)
//   z_out            : updated angle accumulator
module cordic_stage #(
    parameter int XY_W = 15,
    parameter int Z_W  = 18
) (
    input  logic signed [XY_W-1:0] x_in,
    input  logic signed [XY_W-1:0] y_in,
    input  logic        [Z_W-1:0]  z_in,
    input  logic        [3:0]      shift,
    input  logic        [Z_W-1:0]  angle,
    output logic signed [XY_W-1:0] x_out,
    output logic signed [XY_W-1:0] y_out,
    output logic        [Z_W-1:0]  z_out
);

    logic signed [XY_W-1:0] x_sh;
    logic signed [XY_W-1:0] y_sh;

    // Both shifts use the pre-update operands.
    assign x_sh = x_in >>> shift;
    assign y_sh = y_in >>> shift;

    always_comb begin
        x_out = x_in;
        y_out = y_in;
        z_out = z_in;
        if (!y_in[XY_W-1]) begin
            x_out = x_in + y_sh;
            y_out = y_in - x_sh;
            z_out = z_in + angle;
        end else begin
            x_out = x_in - y_sh;
            y_out = y_in + x_sh;
            z_out = z_in - angle;
        end
    end

endmodule

// File: rtl/cordic_atan2.sv
// Iterative CORDIC atan2 / magnitude unit.
// One sample is accepted in IDLE, rotated for ITER cycles (one micro-rotation
// per cycle through a single shared cordic_stage), then held in DONE until
// downstream takes it.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_i, in_q          : signed cos/sin sample, WIDTH bits
//   in_valid / in_ready : input handshake (ready only in IDLE)
//   phase               : atan2(in_q, in_i) as a 15-bit fraction of a turn
//   mag                 : uncompensated magnitude (gain ~1.6468), WIDTH+2 bits
//   zero_flag           : accepted sample was (0,0)
//   out_valid/out_ready : output handshake (valid only in DONE)
// ITER is meant for 8..16.
module cordic_atan2
    import cordic_atan2_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int ITER  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_i,
    input  logic signed [WIDTH-1:0] in_q,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [PHASE_W-1:0]      phase,
    output logic [WIDTH+1:0]        mag,
    output logic                    zero_flag,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Two extra integer bits cover negating -2^(WIDTH-1) and the CORDIC gain.
    localparam int XY_W  = WIDTH + 2 + XY_FRAC;
    localparam int CNT_W = 5;

    state_t state, state_nxt;

    logic        [CNT_W-1:0] cnt;
    logic signed [XY_W-1:0]  x_r, y_r;
    logic        [Z_W-1:0]   z_r;
    logic                    zero_r;

    logic signed [XY_W-1:0]  x_nx, y_nx;
    logic        [Z_W-1:0]   z_nx;
    logic        [Z_W-1:0]   z_rnd;

    logic signed [WIDTH+1:0] i_ext, q_ext;
    logic signed [WIDTH+1:0] x_ld, y_ld;
    logic                    i_neg;
    logic                    rot_last;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE) && !rst;

    assign rot_last  = (cnt == CNT_W'(ITER));

    // Pre-rotation folds the left half-plane onto the right one by a 180
    // degree turn, keeping every angle inside CORDIC's convergence range.
    assign i_ext = {{2{in_i[WIDTH-1]}}, in_i};
    assign q_ext = {{2{in_q[WIDTH-1]}}, in_q};
    assign i_neg = in_i[WIDTH-1];
    assign x_ld  = i_neg ? -i_ext : i_ext;
    assign y_ld  = i_neg ? -q_ext : q_ext;

    // Round half-up from the guarded accumulator; wrap is natural modulo.
    assign z_rnd = z_r + Z_W'(1 << (Z_GUARD - 1));

    cordic_stage #(
        .XY_W (XY_W),
        .Z_W  (Z_W)
    ) u_stage (
        .x_in  (x_r),
        .y_in  (y_r),
        .z_in  (z_r),
        .shift (cnt[3:0]),
        .angle (ATAN_TAB[cnt[3:0]]),
        .x_out (x_nx),
        .y_out (y_nx),
        .z_out (z_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ROT;
            ROT:     if (rot_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ROT spends ITER cycles rotating plus one cycle registering the result,
    // giving ITER+1 cycles from acceptance to out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            zero_r    <= 1'b0;
            phase     <= '0;
            mag       <= '0;
            zero_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r    <= {x_ld, {XY_FRAC{1'b0}}};
                        y_r    <= {y_ld, {XY_FRAC{1'b0}}};
                        z_r    <= i_neg ? phase_to_z(HALF) : '0;
                        zero_r <= (in_i == '0) && (in_q == '0);
                        cnt    <= '0;
                    end
                end
                ROT: begin
                    if (!rot_last) begin
                        x_r <= x_nx;
                        y_r <= y_nx;
                        z_r <= z_nx;
                        cnt <= cnt + 1'b1;
                    end else begin
                        // (0,0) would otherwise report the sum of all table angles.
                        phase     <= zero_r ? '0 : z_rnd[Z_W-1:Z_GUARD];
                        mag       <= zero_r ? '0 : x_r[XY_W-1:XY_FRAC];
                        zero_flag <= zero_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_atan2.sv
module tb_cordic_atan2;

    localparam int W    = 9;
    localparam int IT   = 12;
    localparam int LAT  = IT + 1;
    localparam int TOUT = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] in_i, in_q;
    logic                in_valid;
    logic                in_ready;
    logic [14:0]         phase;
    logic [W+1:0]        mag;
    logic                zero_flag;
    logic                out_valid;
    logic                out_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cordic_atan2 #(.WIDTH(W), .ITER(IT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_i      (in_i),
        .in_q      (in_q),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .phase     (phase),
        .mag       (mag),
        .zero_flag (zero_flag),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        int i;
        int q;
        int ph;
        int ph_tol;
        int mg;
        int mg_tol;
        int zf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int got, input int exp, input int tol);
        int d;
        n_vec++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, got, exp, tol);
        end
    endtask

    task automatic chk_ph(input string name, input int got, input int exp, input int tol);
        int d;
        n_vec++;
        d = (got - exp) % 32768;
        if (d > 16384)  d -= 32768;
        if (d < -16384) d += 32768;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h (+/-%0d)", name, got, exp, tol);
        end
    endtask

    // Presents one sample and returns at the negedge right after the accepting edge.
    task automatic accept(input int i, input int q);
        int w;
        in_i     = W'(i);
        in_q     = W'(q);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < TOUT) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < TOUT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_one(input int i, input int q, output int ph, output int mg,
                           output int zf, output int lat);
        accept(i, q);
        wait_result(lat);
        ph = int'(phase);
        mg = int'(mag);
        zf = int'(zero_flag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int ph, mg, zf, lat;
        int ph0, mg0, zf0;
        bit seen;

        vecs[0] = '{ 100,    0, 16'h0000, 3, 164, 2, 0};
        vecs[1] = '{   0,  100, 16'h2000, 3, 164, 2, 0};
        vecs[2] = '{-100,    0, 16'h4000, 3, 164, 2, 0};
        vecs[3] = '{   0, -100, 16'h6000, 3, 164, 2, 0};
        vecs[4] = '{ 100,  100, 16'h1000, 3, 232, 2, 0};
        vecs[5] = '{-256,    0, 16'h4000, 3, 421, 2, 0};
        vecs[6] = '{   0,    0, 16'h0000, 0,   0, 0, 1};
        vecs[7] = '{-100, -100, 16'h5000, 3, 232, 2, 0};

        // Reset, with in_valid asserted throughout to show reset wins.
        rst = 1'b1; in_valid = 1'b1; in_i = W'(50); in_q = W'(50); out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  int'(in_ready),  0, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_phase",     int'(phase),     0, 0);
        chk("rst_mag",       int'(mag),       0, 0);
        chk("rst_zero_flag", int'(zero_flag), 0, 0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1, 0);
        seen = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("rst_no_spurious", int'(seen), 0, 0);

        // Directed vector table.
        foreach (vecs[k]) begin
            run_one(vecs[k].i, vecs[k].q, ph, mg, zf, lat);
            chk("latency", lat, LAT, 0);
            chk_ph("phase", ph, vecs[k].ph, vecs[k].ph_tol);
            chk("mag", mg, vecs[k].mg, vecs[k].mg_tol);
            chk("zero_flag", zf, vecs[k].zf, 0);
        end

        // Backpressure: hold the result, ignore new samples.
        accept(0, 100);
        wait_result(lat);
        chk("bp_latency", lat, LAT, 0);
        ph0 = int'(phase); mg0 = int'(mag); zf0 = int'(zero_flag);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_i = W'(-77); in_q = W'(33);
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1, 0);
            chk("bp_in_ready",  int'(in_ready),  0, 0);
            chk("bp_phase",     int'(phase),     ph0, 0);
            chk("bp_mag",       int'(mag),       mg0, 0);
            chk("bp_zero_flag", int'(zero_flag), zf0, 0);
        end
        in_valid = 1'b0;
        chk_ph("bp_value", ph0, 16'h2000, 3);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("retire_out_valid", int'(out_valid), 0, 0);
        chk("retire_in_ready",  int'(in_ready),  1, 0);
        seen = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("bp_pulses_ignored", int'(seen), 0, 0);

        // Reset during rotation: iteration 6 runs on the 7th edge after acceptance.
        accept(100, 0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (LAT + 6) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("abort_no_result", int'(seen), 0, 0);
        run_one(0, 50, ph, mg, zf, lat);
        chk("after_abort_latency", lat, LAT, 0);
        chk_ph("after_abort_phase", ph, 16'h2000, 3);

        // Round trip over a 1024-point circle of 9-bit cos/sin samples.
        for (int n = 0; n < 1024; n++) begin
            int  p, ci, si;
            real a;
            p  = n * 32;
            a  = real'(p) * 2.0 * 3.14159265358979 / 32768.0;
            ci = int'(255.0 * $cos(a));
            si = int'(255.0 * $sin(a));
            run_one(ci, si, ph, mg, zf, lat);
            chk_ph("sweep_phase", ph, p, 24);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
